// File: rtl/rc_pkg.sv
// Shared state encoding, default constants and slope field helpers used by
// the rate-control offset tracker and its fractional accumulator.
package rc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_RUN,
        ST_RAMP,
        ST_DONE
    } rc_state_e;

    localparam int RC_OFFSET_INIT_DEFAULT  = 8192;
    localparam int RC_AVE_BLK_BITS_DEFAULT = 128;
    localparam int RC_BLK_PIX_DEFAULT      = 16;

    // The slope word carries the integer step in its MSBs and the fraction in
    // the fracW LSBs; callers cast the results down to their own field widths.
    function automatic logic [63:0] slopeFracPart(input logic [63:0] slope,
                                                  input int unsigned fracW);
        return slope & ((64'd1 << fracW) - 64'd1);
    endfunction

    function automatic logic [63:0] slopeIntPart(input logic [63:0] slope,
                                                 input int unsigned fracW);
        return slope >> fracW;
    endfunction

endpackage

// File: rtl/rc_frac_accum.sv
// Fractional slope accumulator with a saturating fullness-offset adder,
// including the half-LSB rounding applied on the last block of a slice.
module rc_frac_accum
    import rc_pkg::*;
#(
    parameter int OFF_W  = 16,
    parameter int FRAC_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    clear_i,
    input  logic                    step_i,
    input  logic                    last_i,
    input  logic [OFF_W+FRAC_W-1:0] slope_i,
    output logic [OFF_W-1:0]        offset_o
);

    logic [FRAC_W-1:0] accum_q, accum_d;
    logic [OFF_W-1:0]  offset_q, offset_d;
    logic [OFF_W-1:0]  slopeInt;
    logic [FRAC_W-1:0] slopeFrac;
    logic [FRAC_W:0]   sumFrac;
    logic [FRAC_W-1:0] accNew;
    logic              carry;
    logic              roundUp;
    logic [OFF_W+1:0]  addend;
    logic [OFF_W+1:0]  wideSum;

    assign slopeInt  = OFF_W'(slopeIntPart(64'(slope_i), FRAC_W));
    assign slopeFrac = FRAC_W'(slopeFracPart(64'(slope_i), FRAC_W));

    // Rounding looks at the accumulator value after this block's step, so a
    // carry out of the fraction and the round-up can both land on one block.
    always_comb begin
        sumFrac  = {1'b0, accum_q} + {1'b0, slopeFrac};
        accNew   = step_i ? sumFrac[FRAC_W-1:0] : accum_q;
        carry    = step_i & sumFrac[FRAC_W];
        roundUp  = last_i & accNew[FRAC_W-1];
        addend   = (step_i ? {2'b00, slopeInt} : '0)
                 + {{(OFF_W+1){1'b0}}, carry}
                 + {{(OFF_W+1){1'b0}}, roundUp};
        wideSum  = {2'b00, offset_q} + addend;
        accum_d  = accNew;
        offset_d = (wideSum > {2'b00, {OFF_W{1'b1}}}) ? {OFF_W{1'b1}} : wideSum[OFF_W-1:0];
        if (clear_i) begin
            accum_d  = '0;
            offset_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            accum_q  <= '0;
            offset_q <= '0;
        end else begin
            accum_q  <= accum_d;
            offset_q <= offset_d;
        end
    end

    assign offset_o = offset_q;

endmodule

// File: rtl/rc_offset_tracker.sv
// Per-slice tracker of the initial-delay offset and the end-of-slice buffer
// fullness ramp offset, advanced once per coded block.
module rc_offset_tracker
    import rc_pkg::*;
#(
    parameter int OFF_W   = 16,
    parameter int FRAC_W  = 16,
    parameter int CNT_W   = 16,
    parameter int BLK_PIX = RC_BLK_PIX_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    slice_start,
    input  logic                    blk_done,
    input  logic [7:0]              m_numBlksInLine,
    input  logic [CNT_W-1:0]        m_numBlksInSlice,
    input  logic [7:0]              r_initTxDelay,
    input  logic [15:0]             r_rcBufferFullnessOffsetThd,
    input  logic [OFF_W+FRAC_W-1:0] r_rcFullnessSlope,
    input  logic [OFF_W-1:0]        r_rcOffsetInitStart,
    input  logic [11:0]             r_aveBlkBits,
    output logic [OFF_W-1:0]        m_rcOffsetInit,
    output logic [OFF_W-1:0]        m_rcOffset,
    output logic [CNT_W-1:0]        m_blkCnt,
    output logic                    offset_valid,
    output logic                    slice_end
);

    localparam int PROD_W = 24;
    localparam int TH_W   = ((CNT_W > PROD_W) ? CNT_W : PROD_W) + 1;
    localparam int CMP_W  = ((CNT_W + 1) > 8) ? (CNT_W + 1) : 8;
    localparam int DEC_W  = ((OFF_W > 12) ? OFF_W : 12) + 1;

    if (BLK_PIX < 1 || (BLK_PIX & (BLK_PIX - 1)) != 0) begin : gBlkPixCheck
        $error("rc_offset_tracker: BLK_PIX must be a power of two");
    end

    rc_state_e         state_q, state_d;
    logic [CNT_W-1:0]  blkCnt_q, blkCnt_d;
    logic [CNT_W-1:0]  th_q, th_d;
    logic [OFF_W-1:0]  offInit_q, offInit_d;
    logic              valid_q, valid_d;

    logic signed [TH_W-1:0] thSigned;
    logic [CNT_W-1:0]       thClamped;
    logic [DEC_W-1:0]       decDiff;
    logic [OFF_W-1:0]       offInitDec;
    logic [CNT_W:0]         blkNext;
    logic                   accept;
    logic                   initDec;
    logic                   lastBlk;
    logic                   rampNow;
    logic                   rampStep;
    logic                   lastStep;

    // Ramp start threshold: the product is widened before subtracting so a
    // large lines*threshold drives the result negative and clamps to zero.
    always_comb begin
        thSigned  = $signed(TH_W'(m_numBlksInSlice))
                  - $signed(TH_W'(m_numBlksInLine) * TH_W'(r_rcBufferFullnessOffsetThd));
        thClamped = thSigned[TH_W-1] ? '0 : CNT_W'(thSigned);
    end

    always_comb begin
        decDiff    = DEC_W'(offInit_q) - DEC_W'(r_aveBlkBits);
        offInitDec = decDiff[DEC_W-1] ? '0 : OFF_W'(decDiff);
        blkNext    = {1'b0, blkCnt_q} + {{CNT_W{1'b0}}, 1'b1};
        accept     = blk_done && !slice_start
                   && (state_q inside {ST_INIT, ST_RUN, ST_RAMP});
        initDec    = CMP_W'(blkNext) <= CMP_W'(r_initTxDelay);
        lastBlk    = blkNext == {1'b0, m_numBlksInSlice};
        rampNow    = (state_q == ST_RAMP) || (blkCnt_q >= th_q);
        rampStep   = accept && rampNow;
        lastStep   = accept && lastBlk;
    end

    // The block that first reaches the threshold is already treated as a ramp
    // block, and the initial-delay decrement runs alongside it if still due.
    always_comb begin
        state_d   = state_q;
        blkCnt_d  = blkCnt_q;
        th_d      = th_q;
        offInit_d = offInit_q;
        valid_d   = 1'b0;
        if (slice_start) begin
            state_d   = (m_numBlksInSlice == '0) ? ST_DONE : ST_INIT;
            blkCnt_d  = '0;
            th_d      = thClamped;
            offInit_d = r_rcOffsetInitStart;
        end else if (accept) begin
            blkCnt_d = blkNext[CNT_W-1:0];
            valid_d  = 1'b1;
            if (initDec) begin
                offInit_d = offInitDec;
            end
            if (lastBlk) begin
                state_d = ST_DONE;
            end else if (rampNow) begin
                state_d = ST_RAMP;
            end else if (state_q == ST_INIT && !initDec) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            blkCnt_q  <= '0;
            th_q      <= '0;
            offInit_q <= OFF_W'(RC_OFFSET_INIT_DEFAULT);
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            blkCnt_q  <= blkCnt_d;
            th_q      <= th_d;
            offInit_q <= offInit_d;
            valid_q   <= valid_d;
        end
    end

    rc_frac_accum #(
        .OFF_W  (OFF_W),
        .FRAC_W (FRAC_W)
    ) uAccum (
        .clk      (clk),
        .rstn     (rstn),
        .clear_i  (slice_start),
        .step_i   (rampStep),
        .last_i   (lastStep),
        .slope_i  (r_rcFullnessSlope),
        .offset_o (m_rcOffset)
    );

    assign m_rcOffsetInit = offInit_q;
    assign m_blkCnt       = blkCnt_q;
    assign offset_valid   = valid_q;
    assign slice_end      = (state_q == ST_DONE);

endmodule

// File: tb/tb_rc_offset_tracker.sv
// Self-checking bench for rc_offset_tracker: directed scenarios plus random
// slices compared against a block-level arithmetic model of the offsets.
`timescale 1ns/1ps
module tb_rc_offset_tracker;
    import rc_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        slice_start, blk_done;
    logic [7:0]  numLine;
    logic [15:0] numSlice;
    logic [7:0]  txDelay;
    logic [15:0] thd;
    logic [31:0] slope;
    logic [15:0] initStart;
    logic [11:0] aveBits;
    logic [15:0] rcOffsetInit, rcOffset, blkCnt;
    logic        offsetValid, sliceEnd;

    logic        s1Start, s1Blk;
    logic [23:0] s1Slope;
    logic [7:0]  s1InitStart;
    logic [7:0]  s1OffInit, s1Offset;
    logic [15:0] s1BlkCnt;
    logic        s1Valid, s1End;

    int nChecks = 0;
    int nFail   = 0;

    // Block-level model of one slice
    bit mActive, mDone, mValid;
    int mN, mTh, mDelay, mAve, mOffInit, mRc, mAcc, mSlopeInt, mSlopeFrac, mCnt;

    rc_offset_tracker dut (
        .clk                         (clk),
        .rstn                        (rstn),
        .slice_start                 (slice_start),
        .blk_done                    (blk_done),
        .m_numBlksInLine             (numLine),
        .m_numBlksInSlice            (numSlice),
        .r_initTxDelay               (txDelay),
        .r_rcBufferFullnessOffsetThd (thd),
        .r_rcFullnessSlope           (slope),
        .r_rcOffsetInitStart         (initStart),
        .r_aveBlkBits                (aveBits),
        .m_rcOffsetInit              (rcOffsetInit),
        .m_rcOffset                  (rcOffset),
        .m_blkCnt                    (blkCnt),
        .offset_valid                (offsetValid),
        .slice_end                   (sliceEnd)
    );

    rc_offset_tracker #(.OFF_W(8), .FRAC_W(16), .CNT_W(16)) dutSmall (
        .clk                         (clk),
        .rstn                        (rstn),
        .slice_start                 (s1Start),
        .blk_done                    (s1Blk),
        .m_numBlksInLine             (8'd8),
        .m_numBlksInSlice            (16'd3),
        .r_initTxDelay               (8'd0),
        .r_rcBufferFullnessOffsetThd (16'd1),
        .r_rcFullnessSlope           (s1Slope),
        .r_rcOffsetInitStart         (s1InitStart),
        .r_aveBlkBits                (12'd16),
        .m_rcOffsetInit              (s1OffInit),
        .m_rcOffset                  (s1Offset),
        .m_blkCnt                    (s1BlkCnt),
        .offset_valid                (s1Valid),
        .slice_end                   (s1End)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic modelReset();
        mActive = 0; mDone = 0; mValid = 0;
        mOffInit = 8192; mRc = 0; mAcc = 0; mCnt = 0;
    endtask

    task automatic modelStart();
        mN = int'(numSlice);
        mTh = mN - int'(numLine) * int'(thd);
        if (mTh < 0) mTh = 0;
        mDelay = int'(txDelay); mAve = int'(aveBits); mOffInit = int'(initStart);
        mSlopeInt = int'(slope[31:16]); mSlopeFrac = int'(slope[15:0]);
        mRc = 0; mAcc = 0; mCnt = 0; mValid = 0;
        mDone = (mN == 0); mActive = (mN != 0);
    endtask

    task automatic modelBlock();
        int n;
        mValid = 0;
        if (!mActive) return;
        n = mCnt + 1;
        if (n <= mDelay) mOffInit = (mOffInit > mAve) ? mOffInit - mAve : 0;
        if (mCnt >= mTh) begin
            mAcc = mAcc + mSlopeFrac;
            mRc  = mRc + mSlopeInt + ((mAcc >= 65536) ? 1 : 0);
            mAcc = mAcc % 65536;
            if (mRc > 65535) mRc = 65535;
        end
        if (n == mN) begin
            if (mAcc >= 32768) mRc = (mRc >= 65535) ? 65535 : mRc + 1;
            mActive = 0; mDone = 1;
        end
        mCnt = n; mValid = 1;
    endtask

    // One clock of stimulus on the main DUT, mirrored into the model
    task automatic applyStimulus(input logic ss, input logic bd);
        @(negedge clk);
        slice_start = ss; blk_done = bd;
        @(posedge clk);
        #1;
        slice_start = 1'b0; blk_done = 1'b0;
        if (ss) modelStart();
        else if (bd) modelBlock();
        else mValid = 0;
    endtask

    task automatic applyStimulusSmall(input logic ss, input logic bd);
        @(negedge clk);
        s1Start = ss; s1Blk = bd;
        @(posedge clk);
        #1;
        s1Start = 1'b0; s1Blk = 1'b0;
    endtask

    task automatic setConfig(input int n, input int line, input int th, input int dly,
                             input logic [31:0] slp, input int st, input int ave);
        numSlice = 16'(n); numLine = 8'(line); thd = 16'(th); txDelay = 8'(dly);
        slope = slp; initStart = 16'(st); aveBits = 12'(ave);
    endtask

    task automatic test_reset();
        rstn = 1'b0; slice_start = 0; blk_done = 0; s1Start = 0; s1Blk = 0;
        s1Slope = 24'h0; s1InitStart = 8'd0;
        setConfig(1, 1, 0, 0, 32'h0, 8192, 128);
        modelReset();
        repeat (3) @(negedge clk);
        nChecks += 6;
        if (rcOffsetInit !== 16'd8192) begin nFail++; $display("[TB] FAIL reset_offInit: got %0d, expected 8192", rcOffsetInit); end
        if (rcOffset !== 16'd0) begin nFail++; $display("[TB] FAIL reset_offset: got %0d, expected 0", rcOffset); end
        if (blkCnt !== 16'd0) begin nFail++; $display("[TB] FAIL reset_blkCnt: got %0d, expected 0", blkCnt); end
        if (offsetValid !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid: got %0b, expected 0", offsetValid); end
        if (sliceEnd !== 1'b0) begin nFail++; $display("[TB] FAIL reset_sliceEnd: got %0b, expected 0", sliceEnd); end
        if (s1OffInit !== 8'd0) begin nFail++; $display("[TB] FAIL reset_offInit8: got %0d, expected 0", s1OffInit); end
        rstn = 1'b1;
        applyStimulus(0, 1);
        nChecks += 2;
        if (offsetValid !== 1'b0) begin nFail++; $display("[TB] FAIL idle_blk_valid: got %0b, expected 0", offsetValid); end
        if (blkCnt !== 16'd0) begin nFail++; $display("[TB] FAIL idle_blk_cnt: got %0d, expected 0", blkCnt); end
    endtask

    task automatic test_init_decrement();
        int expInit[6] = '{8064, 7936, 7808, 7680, 7680, 7680};
        setConfig(20, 1, 0, 4, 32'h0, 8192, RC_AVE_BLK_BITS_DEFAULT);
        applyStimulus(1, 0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1);
            nChecks += 3;
            if (rcOffsetInit !== 16'(expInit[i])) begin nFail++; $display("[TB] FAIL init_dec blk%0d: got %0d, expected %0d", i + 1, rcOffsetInit, expInit[i]); end
            if (blkCnt !== 16'(i + 1)) begin nFail++; $display("[TB] FAIL init_cnt blk%0d: got %0d, expected %0d", i + 1, blkCnt, i + 1); end
            if (offsetValid !== 1'b1) begin nFail++; $display("[TB] FAIL init_valid blk%0d: got %0b, expected 1", i + 1, offsetValid); end
        end
    endtask

    task automatic test_ramp_carry();
        int expRc[10] = '{0, 0, 0, 0, 0, 0, 1, 3, 4, 6};
        setConfig(10, 2, 2, 0, 32'h0001_8000, 8192, 128);
        applyStimulus(1, 0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 1);
            nChecks += 2;
            if (rcOffset !== 16'(expRc[i])) begin nFail++; $display("[TB] FAIL ramp_rc blk%0d: got %0d, expected %0d", i + 1, rcOffset, expRc[i]); end
            if (sliceEnd !== (i == 9)) begin nFail++; $display("[TB] FAIL ramp_end blk%0d: got %0b, expected %0b", i + 1, sliceEnd, (i == 9)); end
        end
        applyStimulus(0, 1);
        nChecks += 3;
        if (offsetValid !== 1'b0) begin nFail++; $display("[TB] FAIL done_valid: got %0b, expected 0", offsetValid); end
        if (blkCnt !== 16'd10) begin nFail++; $display("[TB] FAIL done_cnt: got %0d, expected 10", blkCnt); end
        if (rcOffset !== 16'd6) begin nFail++; $display("[TB] FAIL done_rc: got %0d, expected 6", rcOffset); end
    endtask

    task automatic test_th_clamp();
        setConfig(4, 8, 1, 0, 32'h0002_0000, 8192, 128);
        applyStimulus(1, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 1);
            nChecks++;
            if (rcOffset !== 16'(2 * (i + 1))) begin nFail++; $display("[TB] FAIL clamp_rc blk%0d: got %0d, expected %0d", i + 1, rcOffset, 2 * (i + 1)); end
        end
        nChecks++;
        if (sliceEnd !== 1'b1) begin nFail++; $display("[TB] FAIL clamp_end: got %0b, expected 1", sliceEnd); end
    endtask

    task automatic test_rounding();
        setConfig(2, 1, 2, 0, 32'h0000_6000, 8192, 128);
        applyStimulus(1, 0);
        applyStimulus(0, 1);
        nChecks++;
        if (rcOffset !== 16'd0) begin nFail++; $display("[TB] FAIL round_rc blk1: got %0d, expected 0", rcOffset); end
        applyStimulus(0, 1);
        nChecks += 2;
        if (rcOffset !== 16'd1) begin nFail++; $display("[TB] FAIL round_rc blk2: got %0d, expected 1", rcOffset); end
        if (sliceEnd !== 1'b1) begin nFail++; $display("[TB] FAIL round_end: got %0b, expected 1", sliceEnd); end
    endtask

    task automatic test_collision();
        setConfig(10, 1, 10, 5, 32'h0001_0000, 5000, 100);
        applyStimulus(1, 0);
        applyStimulus(0, 1);
        applyStimulus(0, 1);
        nChecks += 2;
        if (rcOffset !== 16'd2) begin nFail++; $display("[TB] FAIL coll_pre_rc: got %0d, expected 2", rcOffset); end
        if (rcOffsetInit !== 16'd4800) begin nFail++; $display("[TB] FAIL coll_pre_init: got %0d, expected 4800", rcOffsetInit); end
        applyStimulus(1, 1);
        nChecks += 4;
        if (blkCnt !== 16'd0) begin nFail++; $display("[TB] FAIL coll_cnt: got %0d, expected 0", blkCnt); end
        if (offsetValid !== 1'b0) begin nFail++; $display("[TB] FAIL coll_valid: got %0b, expected 0", offsetValid); end
        if (rcOffset !== 16'd0) begin nFail++; $display("[TB] FAIL coll_rc: got %0d, expected 0", rcOffset); end
        if (rcOffsetInit !== 16'd5000) begin nFail++; $display("[TB] FAIL coll_init: got %0d, expected 5000", rcOffsetInit); end
        applyStimulus(0, 1);
        nChecks += 3;
        if (blkCnt !== 16'd1) begin nFail++; $display("[TB] FAIL coll_post_cnt: got %0d, expected 1", blkCnt); end
        if (rcOffset !== 16'd1) begin nFail++; $display("[TB] FAIL coll_post_rc: got %0d, expected 1", rcOffset); end
        if (rcOffsetInit !== 16'd4900) begin nFail++; $display("[TB] FAIL coll_post_init: got %0d, expected 4900", rcOffsetInit); end
    endtask

    task automatic test_zero_blocks();
        setConfig(0, 2, 1, 3, 32'h0001_0000, 1234, 10);
        applyStimulus(1, 0);
        nChecks++;
        if (sliceEnd !== 1'b1) begin nFail++; $display("[TB] FAIL zero_end: got %0b, expected 1", sliceEnd); end
        applyStimulus(0, 1);
        nChecks += 2;
        if (offsetValid !== 1'b0) begin nFail++; $display("[TB] FAIL zero_valid: got %0b, expected 0", offsetValid); end
        if (blkCnt !== 16'd0) begin nFail++; $display("[TB] FAIL zero_cnt: got %0d, expected 0", blkCnt); end
    endtask

    task automatic test_saturation();
        int expRc[3] = '{200, 255, 255};
        s1Slope = {8'd200, 16'h0000};
        s1InitStart = 8'd50;
        applyStimulusSmall(1, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulusSmall(0, 1);
            nChecks += 2;
            if (s1Offset !== 8'(expRc[i])) begin nFail++; $display("[TB] FAIL sat_rc blk%0d: got %0d, expected %0d", i + 1, s1Offset, expRc[i]); end
            if (s1OffInit !== 8'd50) begin nFail++; $display("[TB] FAIL sat_init blk%0d: got %0d, expected 50", i + 1, s1OffInit); end
        end
        applyStimulusSmall(0, 1);
        nChecks += 4;
        if (s1Valid !== 1'b0) begin nFail++; $display("[TB] FAIL sat_done_valid: got %0b, expected 0", s1Valid); end
        if (s1BlkCnt !== 16'd3) begin nFail++; $display("[TB] FAIL sat_done_cnt: got %0d, expected 3", s1BlkCnt); end
        if (s1Offset !== 8'd255) begin nFail++; $display("[TB] FAIL sat_done_rc: got %0d, expected 255", s1Offset); end
        if (s1End !== 1'b1) begin nFail++; $display("[TB] FAIL sat_done_end: got %0b, expected 1", s1End); end
    endtask

    task automatic test_reset_mid_ramp();
        setConfig(12, 1, 6, 3, 32'h0003_4000, 1000, 300);
        applyStimulus(1, 0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1);
            nChecks += 3;
            if (rcOffset !== 16'(mRc)) begin nFail++; $display("[TB] FAIL midrst_pre_rc blk%0d: got %0d, expected %0d", i + 1, rcOffset, mRc); end
            if (rcOffsetInit !== 16'(mOffInit)) begin nFail++; $display("[TB] FAIL midrst_pre_init blk%0d: got %0d, expected %0d", i + 1, rcOffsetInit, mOffInit); end
            if (blkCnt !== 16'(mCnt)) begin nFail++; $display("[TB] FAIL midrst_pre_cnt blk%0d: got %0d, expected %0d", i + 1, blkCnt, mCnt); end
        end
        @(negedge clk);
        #2 rstn = 1'b0;
        modelReset();
        #1;
        nChecks += 5;
        if (rcOffsetInit !== 16'd8192) begin nFail++; $display("[TB] FAIL midrst_init: got %0d, expected 8192", rcOffsetInit); end
        if (rcOffset !== 16'd0) begin nFail++; $display("[TB] FAIL midrst_rc: got %0d, expected 0", rcOffset); end
        if (blkCnt !== 16'd0) begin nFail++; $display("[TB] FAIL midrst_cnt: got %0d, expected 0", blkCnt); end
        if (offsetValid !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_valid: got %0b, expected 0", offsetValid); end
        if (sliceEnd !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_end: got %0b, expected 0", sliceEnd); end
        @(negedge clk);
        rstn = 1'b1;
        applyStimulus(0, 1);
        nChecks++;
        if (offsetValid !== 1'b0) begin nFail++; $display("[TB] FAIL midrst_idle_valid: got %0b, expected 0", offsetValid); end
        applyStimulus(1, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(0, 1);
            nChecks += 2;
            if (rcOffset !== 16'(mRc)) begin nFail++; $display("[TB] FAIL midrst_post_rc blk%0d: got %0d, expected %0d", i + 1, rcOffset, mRc); end
            if (rcOffsetInit !== 16'(mOffInit)) begin nFail++; $display("[TB] FAIL midrst_post_init blk%0d: got %0d, expected %0d", i + 1, rcOffsetInit, mOffInit); end
        end
        nChecks++;
        if (sliceEnd !== 1'b1) begin nFail++; $display("[TB] FAIL midrst_post_end: got %0b, expected 1", sliceEnd); end
    endtask

    task automatic test_random();
        for (int s = 0; s < 12; s++) begin
            logic [31:0] slp;
            int steps;
            slp = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 65535))};
            if ($urandom_range(0, 3) == 0) slp[31:16] = 16'($urandom_range(0, 65535));
            setConfig(($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 30),
                      $urandom_range(1, 8), $urandom_range(0, 5), $urandom_range(0, 12),
                      slp, $urandom_range(0, 65535), $urandom_range(0, 4095));
            applyStimulus(1, 0);
            steps = mN + 6;
            for (int k = 0; k < steps; k++) begin
                int r;
                r = $urandom_range(0, 31);
                if (r == 0) applyStimulus(1, 1);
                else if (r < 6) applyStimulus(0, 0);
                else applyStimulus(0, 1);
                nChecks += 5;
                if (rcOffset !== 16'(mRc)) begin nFail++; $display("[TB] FAIL rand_rc s%0d k%0d: got %0d, expected %0d", s, k, rcOffset, mRc); end
                if (rcOffsetInit !== 16'(mOffInit)) begin nFail++; $display("[TB] FAIL rand_init s%0d k%0d: got %0d, expected %0d", s, k, rcOffsetInit, mOffInit); end
                if (blkCnt !== 16'(mCnt)) begin nFail++; $display("[TB] FAIL rand_cnt s%0d k%0d: got %0d, expected %0d", s, k, blkCnt, mCnt); end
                if (offsetValid !== mValid) begin nFail++; $display("[TB] FAIL rand_valid s%0d k%0d: got %0b, expected %0b", s, k, offsetValid, mValid); end
                if (sliceEnd !== mDone) begin nFail++; $display("[TB] FAIL rand_end s%0d k%0d: got %0b, expected %0b", s, k, sliceEnd, mDone); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_decrement();
        test_ramp_carry();
        test_th_clamp();
        test_rounding();
        test_collision();
        test_zero_blocks();
        test_saturation();
        test_reset_mid_ramp();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
